// File: rtl/dadda_reduce_pipe.sv
// -----------------------------------------------------------------------------
// dadda_reduce_pipe
//
// Pipelined 8x8 multiplier back end. It takes the 64 partial-product bits of
// an 8x8 unsigned multiply and reduces the columns to two rows with a Dadda
// tree. The column-height limits are 6, 4, 3 and 2, and the tree uses only
// full and half adders. A 14-bit ripple carry-propagate adder then forms the
// 16-bit product. A valid/ready handshake sits on both sides.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   pp         in  65   pp[8*i+j] = a[i]&b[j] (weight 2^(i+j)); pp[64] ignored
//   in_valid   in   1   pp carries a bundle
//   in_ready   out  1   bundle accepted on this edge when in_valid=1
//   prod       out 16   registered product
//   out_valid  out  1   prod is valid
//   out_ready  in   1   consumer takes prod on this edge
//   done_cnt   out  8   number of products delivered (wraps)
//
// Build option
//   DADDA_MID_REG_EN  When defined, the two reduced rows are registered
//                     before the carry-propagate adder. Latency becomes 2
//                     and throughput stays at 1 per cycle. When undefined,
//                     the design has a single output register and latency 1.
// -----------------------------------------------------------------------------
module dadda_reduce_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [64:0] pp,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  done_cnt
);

  localparam int NCOL = 15;  // product columns 0..14 before the final carry
  localparam int NSTG = 4;   // reduction stages

  genvar gi;

  // Maximum column height allowed after each reduction stage.
  function automatic int dadda_limit(input int st);
    case (st)
      0:       return 6;
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  // The spare bit carries no weight.
  logic unused_pp_spare;
  assign unused_pp_spare = pp[64];

  // ---------------------------------------------------------------------------
  // Dadda reduction tree.
  // Each column is a small stack of bits. Column c has cur_h[c] live bits.
  // Every stage trims each column to the stage limit. The trim counts the
  // carries that arrive from column c-1 in the same stage. Each full adder
  // removes two bits and each half adder removes one. All heights depend only
  // on constants, so the loops unroll into a fixed adder network.
  // ---------------------------------------------------------------------------
  logic [14:0] tree_a;  // first row, bit c = column c (bit 0 is pp[0])
  logic [13:0] tree_b;  // second row, bit c-1 = column c, columns 1..14

  always_comb begin : dadda_tree
    logic [7:0] cur   [NCOL];
    logic [7:0] nxt   [NCOL];
    int         cur_h [NCOL];
    int         nxt_h [NCOL];
    int         excess;
    int         n_fa;
    int         n_ha;
    int         used;
    logic       x0, x1, x2;

    tree_a = '0;
    tree_b = '0;
    excess = 0;
    n_fa   = 0;
    n_ha   = 0;
    used   = 0;
    x0     = 1'b0;
    x1     = 1'b0;
    x2     = 1'b0;
    for (int c = 0; c < NCOL; c++) begin
      cur[c]   = '0;
      nxt[c]   = '0;
      cur_h[c] = 0;
      nxt_h[c] = 0;
    end

    // Stack the partial products by weight.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        cur[i+j][cur_h[i+j]] = pp[8*i+j];
        cur_h[i+j]           = cur_h[i+j] + 1;
      end
    end

    for (int st = 0; st < NSTG; st++) begin
      for (int c = 0; c < NCOL; c++) begin
        nxt[c]   = '0;
        nxt_h[c] = 0;
      end
      for (int c = 0; c < NCOL; c++) begin
        // nxt_h[c] already holds the carries dropped in by column c-1.
        excess = cur_h[c] + nxt_h[c] - dadda_limit(st);
        n_fa   = (excess > 0) ? excess / 2 : 0;
        n_ha   = (excess > 0) ? excess % 2 : 0;
        used   = 0;
        for (int k = 0; k < 3; k++) begin
          if (k < n_fa) begin
            x0 = cur[c][used];
            x1 = cur[c][used+1];
            x2 = cur[c][used+2];
            nxt[c][nxt_h[c]] = x0 ^ x1 ^ x2;
            nxt_h[c]         = nxt_h[c] + 1;
            if (c < NCOL - 1) begin
              nxt[c+1][nxt_h[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
              nxt_h[c+1]           = nxt_h[c+1] + 1;
            end
            used = used + 3;
          end
        end
        if (n_ha != 0) begin
          x0 = cur[c][used];
          x1 = cur[c][used+1];
          nxt[c][nxt_h[c]] = x0 ^ x1;
          nxt_h[c]         = nxt_h[c] + 1;
          if (c < NCOL - 1) begin
            nxt[c+1][nxt_h[c+1]] = x0 & x1;
            nxt_h[c+1]           = nxt_h[c+1] + 1;
          end
          used = used + 2;
        end
        // Bits that no adder touched pass straight through.
        for (int k = 0; k < 8; k++) begin
          if (k >= used && k < cur_h[c]) begin
            nxt[c][nxt_h[c]] = cur[c][k];
            nxt_h[c]         = nxt_h[c] + 1;
          end
        end
      end
      for (int c = 0; c < NCOL; c++) begin
        cur[c]   = nxt[c];
        cur_h[c] = nxt_h[c];
      end
    end

    // Column 0 holds only pp[0]. Columns 1..14 now hold exactly two bits.
    for (int c = 0; c < NCOL; c++) begin
      tree_a[c] = cur[c][0];
    end
    for (int c = 1; c < NCOL; c++) begin
      tree_b[c-1] = cur[c][1];
    end
  end

  // ---------------------------------------------------------------------------
  // 14-bit ripple carry-propagate adder over columns 1..14. The carry out of
  // column 14 becomes product bit 15.
  // ---------------------------------------------------------------------------
  logic [14:0] cpa_a;
  logic [13:0] cpa_b;
  logic [14:0] cpa_c;
  logic [13:0] cpa_s;
  logic [15:0] cpa_sum;

  assign cpa_c[0] = 1'b0;
  for (gi = 0; gi < 14; gi++) begin : g_cpa
    assign cpa_s[gi]   = cpa_a[gi+1] ^ cpa_b[gi] ^ cpa_c[gi];
    assign cpa_c[gi+1] = (cpa_a[gi+1] & cpa_b[gi]) |
                         (cpa_c[gi] & (cpa_a[gi+1] ^ cpa_b[gi]));
  end
  assign cpa_sum = {cpa_c[14], cpa_s, cpa_a[0]};

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic        out_valid_q, out_valid_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  done_cnt_q, done_cnt_d;
  logic        load_out;   // a fresh product enters the output register
  logic        clear_out;  // the output register empties with nothing behind it

`ifdef DADDA_MID_REG_EN
  logic [14:0] mid_a_q, mid_a_d;
  logic [13:0] mid_b_q, mid_b_d;
  logic        mid_valid_q, mid_valid_d;
  logic        adv_out;

  // The output stage advances when it is empty or is being drained.
  // The middle stage advances when it is empty or feeds a moving output stage.
  assign adv_out   = !out_valid_q || out_ready;
  assign in_ready  = !mid_valid_q || adv_out;
  assign cpa_a     = mid_a_q;
  assign cpa_b     = mid_b_q;
  assign load_out  = adv_out && mid_valid_q;
  assign clear_out = adv_out && !mid_valid_q;

  always_comb begin
    mid_valid_d = mid_valid_q;
    mid_a_d     = mid_a_q;
    mid_b_d     = mid_b_q;
    if (in_ready) begin
      mid_valid_d = in_valid;
      if (in_valid) begin
        mid_a_d = tree_a;
        mid_b_d = tree_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_valid_q <= 1'b0;
      mid_a_q     <= '0;
      mid_b_q     <= '0;
    end else begin
      mid_valid_q <= mid_valid_d;
      mid_a_q     <= mid_a_d;
      mid_b_q     <= mid_b_d;
    end
  end
`else
  assign in_ready  = !out_valid_q || out_ready;
  assign cpa_a     = tree_a;
  assign cpa_b     = tree_b;
  assign load_out  = in_ready && in_valid;
  assign clear_out = in_ready && !in_valid;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    done_cnt_d  = done_cnt_q;
    if (load_out) begin
      out_valid_d = 1'b1;
      prod_d      = cpa_sum;
    end else if (clear_out) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      done_cnt_d = done_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      done_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: doc/dadda_reduce_pipe.md
DADDA_REDUCE_PIPE -- requirements
Module: dadda_reduce_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pp, input, 65 bits: partial-product bus, pp[8*i+j] = a[i]&b[j] with weight 2^(i+j), i,j in 0..7; pp[64] is spare.
REQ-004 SHALL have port in_valid, input, 1 bit: pp holds a valid bundle.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts pp this cycle.
REQ-006 SHALL have port prod, output, 16 bits: the registered product.
REQ-007 SHALL have port out_valid, output, 1 bit: prod is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer takes prod this cycle.
REQ-009 SHALL have port done_cnt, output, 8 bits: count of products delivered.

Function
REQ-010 SHALL accept a bundle on a rising edge where in_valid=1 and in_ready=1.
REQ-011 SHALL deliver a product on a rising edge where out_valid=1 and out_ready=1.
REQ-012 SHALL compute prod = sum of pp[8*i+j]*2^(i+j) over i,j in 0..7, modulo 2^16; the result never exceeds 0xFE01.
REQ-013 SHALL ignore pp[64] in all cases.
REQ-014 SHALL reduce the column heights to 2 using Dadda stages with height limits 6,4,3,2, built from full and half adders only, followed by a 14-bit ripple carry-propagate adder; prod[0] = pp[0].
REQ-015 SHALL drive in_ready = !out_valid || out_ready when DADDA_MID_REG_EN is undefined; no combinational path from in_valid to in_ready.
REQ-016 SHALL assert out_valid on the edge after acceptance when DADDA_MID_REG_EN is undefined (latency 1 cycle).
REQ-017 SHALL hold prod and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL sustain one accept and one deliver per cycle when out_ready=1 continuously (throughput 1/cycle, no bubbles).
REQ-019 SHALL clear out_valid after a delivery edge when no new bundle is accepted on that edge.
REQ-020 SHALL load the new product into prod on an edge where a delivery and an acceptance coincide, keeping out_valid=1.
REQ-021 SHALL increment done_cnt by 1 on each delivery edge, wrapping from 0xFF to 0x00.
REQ-022 SHALL keep out_valid=0 while in_valid=0, regardless of pp content.

Reset
REQ-023 SHALL, while rst_n=0, force out_valid=0, prod=0x0000 and done_cnt=0x00, and clear all internal valid flags, asynchronously.
REQ-024 SHALL discard any bundle in flight when reset is asserted mid-operation; no stale product appears after release.
REQ-025 SHALL accept a bundle on the first rising edge after rst_n deasserts if in_valid=1 (in_ready=1 out of reset).

Configuration
REQ-026 SHALL, when DADDA_MID_REG_EN is defined, insert a register stage (two height-2 rows plus a valid flag) between the reduction tree and the carry-propagate adder, giving latency 2 cycles.
REQ-027 SHALL, with DADDA_MID_REG_EN defined, keep full throughput; the stage-1 register advances when it is empty or stage 2 advances, and in_ready reflects that condition.
REQ-028 SHALL, with DADDA_MID_REG_EN undefined, have a single register stage and latency 1; the port list, done_cnt and the prod values are identical in both builds.

Verification
REQ-029 SHALL cover: a=b=0xFF (pp[63:0] all ones, pp[64]=0), out_ready=1 -> prod=0xFE01, out_valid=1 after 1 cycle (2 with the macro), done_cnt=1.
REQ-030 SHALL cover: pp=0 with pp[64]=1 -> prod=0x0000; then a=0x0D, b=0x0B -> prod=0x008F.
REQ-031 SHALL cover: 300 back-to-back random bundles with out_ready=1 -> each prod matches a*b in order, zero bubbles, done_cnt=300 mod 256=0x2C.
REQ-032 SHALL cover: out_ready=0 for 5 cycles with product 0x3840 (a=0x78, b=0x78) pending -> prod held at 0x3840, in_ready=0, no loss or duplication after out_ready=1.
REQ-033 SHALL cover: rst_n pulsed low with a bundle in flight -> out_valid=0, prod=0x0000, done_cnt=0x00 immediately; next accepted 0x02*0x03 yields prod=0x0006.
REQ-034 SHALL cover: random in_valid and out_ready toggling (50% each) for 1000 cycles in both builds -> results match a scoreboard, prod stable while stalled.
